vga_clkgen_prog: RTL and testbench

VGA_CLKGEN_PROG -- requirements
Module: vga_clkgen_prog

---
 rtl/vga_clkgen_pkg.sv | 44 ++++
 rtl/vga_clkgen_sync.sv | 24 ++
 rtl/vga_clkgen_prog.sv | 254 +++++++++++++++++++++++++
 tb/tb_vga_clkgen_prog.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_clkgen_pkg.sv
// Shared types, constants and command-bit helper for the DCM_CLKGEN programmer.
package vga_clkgen_pkg;

  localparam int unsigned CFG_W      = 8;
  localparam int unsigned BIT_CNT_W  = 4;
  localparam int unsigned LOAD_TICKS = 10;
  localparam int unsigned GAP_TICKS  = 2;
  localparam int unsigned TO_MIN_W   = 16;

  // Two-bit command prefixes; bit 0 goes out on the wire first.
  localparam logic [1:0] CMD_LOAD_D = 2'b01;
  localparam logic [1:0] CMD_LOAD_M = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_D    = 3'd1,
    GAP1      = 3'd2,
    LOAD_M    = 3'd3,
    GAP2      = 3'd4,
    GO        = 3'd5,
    WAIT_DONE = 3'd6,
    WAIT_LOCK = 3'd7
  } state_e;

  typedef struct packed {
    logic [CFG_W-1:0] m;
    logic [CFG_W-1:0] d;
  } cfg_t;

  // Serial bit idx of a load word: prefix (2 bits) then value LSB first.
  function automatic logic cmd_bit(input logic [1:0]           cmd,
                                   input logic [CFG_W-1:0]     val,
                                   input logic [BIT_CNT_W-1:0] idx);
    logic b;
    b = 1'b0;
    if (idx < BIT_CNT_W'(2)) begin
      b = cmd[idx[0]];
    end else if (idx < BIT_CNT_W'(LOAD_TICKS)) begin
      b = val[3'(idx - BIT_CNT_W'(2))];
    end
    return b;
  endfunction

endpackage

// File: rtl/vga_clkgen_sync.sv
// Two-flop synchronizer for a single asynchronous level.
module vga_clkgen_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/vga_clkgen_prog.sv
// Serial programmer for a DCM_CLKGEN: shifts D and M words out on a divided
// programming clock, issues GO, then waits for PROGDONE and LOCKED.
module vga_clkgen_prog
  import vga_clkgen_pkg::*;
#(
  parameter int unsigned PROG_DIV = 2,
  parameter int unsigned TIMEOUT  = 65535
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [CFG_W-1:0] cfg_m,
  input  logic [CFG_W-1:0] cfg_d,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             vga_progclk,
  output logic             vga_progdata,
  output logic             vga_progen,
  input  logic             vga_progdone,
  input  logic             vga_locked
);

  localparam int unsigned DIV_W = (PROG_DIV > 1) ? $clog2(PROG_DIV) : 1;
  localparam int unsigned TO_W  = ($clog2(TIMEOUT + 1) > TO_MIN_W) ? $clog2(TIMEOUT + 1) : TO_MIN_W;

  localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(PROG_DIV - 1);
  localparam logic [TO_W-1:0]      TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]      TO_MAX    = '1;
  localparam logic [BIT_CNT_W-1:0] LOAD_LAST = BIT_CNT_W'(LOAD_TICKS - 1);
  localparam logic [BIT_CNT_W-1:0] GAP_LAST  = BIT_CNT_W'(GAP_TICKS - 1);

  state_e               r_state;
  state_e               w_state_nxt;
  cfg_t                 r_cfg;
  cfg_t                 w_cfg_nxt;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [BIT_CNT_W-1:0] w_bit_nxt;
  logic [BIT_CNT_W-1:0] w_bit_inc;
  logic [TO_W-1:0]      r_to_cnt;
  logic [TO_W-1:0]      w_to_nxt;
  logic [TO_W-1:0]      w_to_inc;
  logic [DIV_W-1:0]     r_div_cnt;
  logic                 r_progclk;
  logic                 r_progdata;
  logic                 r_progen;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_error;
  logic                 w_progdata_nxt;
  logic                 w_progen_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;
  logic                 w_error_nxt;
  logic                 w_tick;
  logic                 w_progdone_s;
  logic                 w_locked_s;

  vga_clkgen_sync u_sync_progdone (
    .i_clk (sys_clk),
    .i_rst (sys_rst),
    .i_d   (vga_progdone),
    .o_q   (w_progdone_s)
  );

  vga_clkgen_sync u_sync_locked (
    .i_clk (sys_clk),
    .i_rst (sys_rst),
    .i_d   (vga_locked),
    .o_q   (w_locked_s)
  );

  // A tick is the edge that drives progclk low; serial outputs advance only here.
  assign w_tick    = r_busy && r_progclk && (r_div_cnt == DIV_LAST);
  assign w_bit_inc = r_bit_cnt + BIT_CNT_W'(1);
  assign w_to_inc  = (r_to_cnt == TO_MAX) ? r_to_cnt : (r_to_cnt + TO_W'(1));

  // Programming clock divider; parked low whenever the block is not busy.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_div_cnt <= '0;
      r_progclk <= 1'b0;
    end else if (!r_busy || !w_busy_nxt) begin
      r_div_cnt <= '0;
      r_progclk <= 1'b0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt <= '0;
      r_progclk <= ~r_progclk;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= IDLE;
      r_cfg      <= '0;
      r_bit_cnt  <= '0;
      r_to_cnt   <= '0;
      r_progdata <= 1'b0;
      r_progen   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cfg      <= w_cfg_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_to_cnt   <= w_to_nxt;
      r_progdata <= w_progdata_nxt;
      r_progen   <= w_progen_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cfg_nxt      = r_cfg;
    w_bit_nxt      = r_bit_cnt;
    w_to_nxt       = '0;
    w_progdata_nxt = r_progdata;
    w_progen_nxt   = r_progen;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_error_nxt    = 1'b0;

    case (r_state)
      IDLE: begin
        w_progdata_nxt = 1'b0;
        w_progen_nxt   = 1'b0;
        w_busy_nxt     = 1'b0;
        if (start) begin
          if (cfg_m != '0) begin
            w_state_nxt    = LOAD_D;
            w_cfg_nxt.m    = cfg_m;
            w_cfg_nxt.d    = cfg_d;
            w_bit_nxt      = '0;
            w_busy_nxt     = 1'b1;
            w_progen_nxt   = 1'b1;
            w_progdata_nxt = cmd_bit(CMD_LOAD_D, cfg_d, '0);
          end else begin
            w_error_nxt = 1'b1;
          end
        end
      end

      LOAD_D: begin
        if (w_tick) begin
          if (r_bit_cnt == LOAD_LAST) begin
            w_state_nxt    = GAP1;
            w_bit_nxt      = '0;
            w_progen_nxt   = 1'b0;
            w_progdata_nxt = 1'b0;
          end else begin
            w_bit_nxt      = w_bit_inc;
            w_progdata_nxt = cmd_bit(CMD_LOAD_D, r_cfg.d, w_bit_inc);
          end
        end
      end

      GAP1: begin
        if (w_tick) begin
          if (r_bit_cnt == GAP_LAST) begin
            w_state_nxt    = LOAD_M;
            w_bit_nxt      = '0;
            w_progen_nxt   = 1'b1;
            w_progdata_nxt = cmd_bit(CMD_LOAD_M, r_cfg.m, '0);
          end else begin
            w_bit_nxt = w_bit_inc;
          end
        end
      end

      LOAD_M: begin
        if (w_tick) begin
          if (r_bit_cnt == LOAD_LAST) begin
            w_state_nxt    = GAP2;
            w_bit_nxt      = '0;
            w_progen_nxt   = 1'b0;
            w_progdata_nxt = 1'b0;
          end else begin
            w_bit_nxt      = w_bit_inc;
            w_progdata_nxt = cmd_bit(CMD_LOAD_M, r_cfg.m, w_bit_inc);
          end
        end
      end

      GAP2: begin
        if (w_tick) begin
          if (r_bit_cnt == GAP_LAST) begin
            w_state_nxt    = GO;
            w_bit_nxt      = '0;
            w_progen_nxt   = 1'b1;
            w_progdata_nxt = 1'b0;
          end else begin
            w_bit_nxt = w_bit_inc;
          end
        end
      end

      GO: begin
        if (w_tick) begin
          w_state_nxt    = WAIT_DONE;
          w_progen_nxt   = 1'b0;
          w_progdata_nxt = 1'b0;
        end
      end

      // Timeout counter restarts from zero on every wait-state entry.
      WAIT_DONE: begin
        if (w_progdone_s) begin
          w_state_nxt = WAIT_LOCK;
        end else if (r_to_cnt >= TO_LAST) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
          w_error_nxt = 1'b1;
        end else begin
          w_to_nxt = w_to_inc;
        end
      end

      WAIT_LOCK: begin
        if (w_locked_s) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else if (r_to_cnt >= TO_LAST) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
          w_error_nxt = 1'b1;
        end else begin
          w_to_nxt = w_to_inc;
        end
      end

      default: begin
        w_state_nxt    = IDLE;
        w_busy_nxt     = 1'b0;
        w_progen_nxt   = 1'b0;
        w_progdata_nxt = 1'b0;
      end
    endcase
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign vga_progclk  = r_progclk;
  assign vga_progdata = r_progdata;
  assign vga_progen   = r_progen;

endmodule

// File: tb/tb_vga_clkgen_prog.sv
// Bench for vga_clkgen_prog: directed and randomized programming runs checked
// against a per-tick model of the serial stream and wait-state timing.
module tb_vga_clkgen_prog;

  localparam int unsigned PD        = 2;
  localparam int unsigned TO        = 100;
  localparam int          T         = 2 * PD;
  localparam int          SEQ_TICKS = 25;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       start;
  logic [7:0] cfg_m;
  logic [7:0] cfg_d;
  logic       busy;
  logic       done;
  logic       error;
  logic       vga_progclk;
  logic       vga_progdata;
  logic       vga_progen;
  logic       vga_progdone;
  logic       vga_locked;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [24:0] obs_data;

  always #5 sys_clk = ~sys_clk;

  vga_clkgen_prog #(.PROG_DIV(PD), .TIMEOUT(TO)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .start        (start),
    .cfg_m        (cfg_m),
    .cfg_d        (cfg_d),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .vga_progclk  (vga_progclk),
    .vga_progdata (vga_progdata),
    .vga_progen   (vga_progen),
    .vga_progdone (vga_progdone),
    .vga_locked   (vga_locked)
  );

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // mode 0: progdone then locked -> done; 1: progdone never -> timeout;
  // 2: progdone but locked never -> timeout in the lock wait.
  task automatic run_seq(input logic [7:0] m, input logic [7:0] d, input int mode, input bit second);
    logic [1:0] q[$];
    int pd_k, lk_k, end_k;
    q = {};
    q.push_back(2'b11);
    q.push_back(2'b10);
    for (int i = 0; i < 8; i++) q.push_back({1'b1, d[i]});
    repeat (2) q.push_back(2'b00);
    q.push_back(2'b11);
    q.push_back(2'b11);
    for (int i = 0; i < 8; i++) q.push_back({1'b1, m[i]});
    repeat (2) q.push_back(2'b00);
    q.push_back(2'b10);

    pd_k = SEQ_TICKS * T + 5 * T;
    lk_k = pd_k + 20;
    case (mode)
      0:       end_k = lk_k + 3;
      1:       end_k = SEQ_TICKS * T + int'(TO);
      default: end_k = pd_k + 3 + int'(TO);
    endcase

    cfg_m = m;
    cfg_d = d;
    start = 1'b1;
    step();
    start = 1'b0;
    cfg_m = 8'($urandom);
    cfg_d = 8'($urandom);

    for (int k = 0; k <= end_k; k++) begin
      if (k < SEQ_TICKS * T) begin
        chk("progen", 32'(vga_progen), 32'(q[k / T][1]));
        chk("progdata", 32'(vga_progdata), 32'(q[k / T][0]));
        if (k % T == 1) obs_data[k / T] = vga_progdata;
      end else begin
        chk("progen_wait", 32'(vga_progen), 32'd0);
        chk("progdata_wait", 32'(vga_progdata), 32'd0);
      end
      chk("done", 32'(done), 32'((mode == 0) && (k == end_k)));
      chk("error", 32'(error), 32'((mode != 0) && (k == end_k)));
      if (k < end_k) begin
        chk("busy", 32'(busy), 32'd1);
        chk("progclk", 32'(vga_progclk), 32'((k / int'(PD)) % 2));
      end
      if (second && k == 3 * T) begin
        start = 1'b1;
        cfg_m = ~m | 8'h01;
        cfg_d = ~d;
      end else begin
        start = 1'b0;
      end
      if (k == pd_k && mode != 1) vga_progdone = 1'b1;
      if (k == lk_k && mode == 0) vga_locked = 1'b1;
      step();
    end
    chk("busy_after", 32'(busy), 32'd0);
    chk("done_after", 32'(done), 32'd0);
    chk("error_after", 32'(error), 32'd0);
    chk("progclk_idle", 32'(vga_progclk), 32'd0);
    chk("progen_idle", 32'(vga_progen), 32'd0);
    vga_progdone = 1'b0;
    vga_locked   = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    sys_rst      = 1'b1;
    start        = 1'b0;
    cfg_m        = 8'h00;
    cfg_d        = 8'h00;
    vga_progdone = 1'b0;
    vga_locked   = 1'b0;
    obs_data     = '0;
    repeat (2) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_progclk", 32'(vga_progclk), 32'd0);
    chk("rst_progdata", 32'(vga_progdata), 32'd0);
    chk("rst_progen", 32'(vga_progen), 32'd0);
    sys_rst = 1'b0;
    step();

    // D-1=3, M-1=5 with a clean done handshake
    run_seq(8'h05, 8'h03, 0, 1'b0);
    chk("load_d_stream", 32'(obs_data[9:0]), 32'h00D);
    chk("load_m_stream", 32'(obs_data[21:12]), 32'h017);

    // M-1 of zero is rejected
    cfg_m = 8'h00;
    cfg_d = 8'($urandom);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rej_error", 32'(error), 32'd1);
    chk("rej_busy", 32'(busy), 32'd0);
    chk("rej_progen", 32'(vga_progen), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rej_error_clr", 32'(error), 32'd0);
      chk("rej_busy_idle", 32'(busy), 32'd0);
      chk("rej_progen_idle", 32'(vga_progen), 32'd0);
      chk("rej_progclk_idle", 32'(vga_progclk), 32'd0);
    end

    run_seq(8'($urandom_range(1, 255)), 8'($urandom), 1, 1'b0);
    run_seq(8'h2A, 8'hC5, 0, 1'b1);

    // Reset while M-1 bit 4 is on the wire
    cfg_m = 8'h05;
    cfg_d = 8'h03;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (18 * T + 1) step();
    chk("pre_rst_progen", 32'(vga_progen), 32'd1);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("mid_rst_progen", 32'(vga_progen), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_progclk", 32'(vga_progclk), 32'd0);
    chk("mid_rst_progdata", 32'(vga_progdata), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_error", 32'(error), 32'd0);
    step();
    sys_rst = 1'b0;
    step();
    chk("post_rst_done", 32'(done), 32'd0);
    chk("post_rst_error", 32'(error), 32'd0);
    run_seq(8'h05, 8'h03, 0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      run_seq(8'($urandom_range(1, 255)), 8'($urandom), int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
